// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave backing store with independent read and write
// engines, one outstanding burst per direction, word-addressed internal RAM.
module axi_mem_responder #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int ID_WIDTH           = 6,
  parameter int MEM_WORDS          = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  // read address channel
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                        s_axi_arlen,
  input  logic [2:0]                        s_axi_arsize,
  input  logic [1:0]                        s_axi_arburst,
  input  logic [ID_WIDTH-1:0]               s_axi_arid,
  // read data channel
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rlast,
  output logic [ID_WIDTH-1:0]               s_axi_rid,
  // write address channel
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                        s_axi_awlen,
  input  logic [2:0]                        s_axi_awsize,
  input  logic [1:0]                        s_axi_awburst,
  input  logic [ID_WIDTH-1:0]               s_axi_awid,
  // write data channel
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wlast,
  // write response channel
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  output logic [1:0]                        s_axi_bresp,
  output logic [ID_WIDTH-1:0]               s_axi_bid
);

  localparam int STRB_W    = C_M_AXI_DATA_WIDTH / 8;
  localparam int BYTE_BITS = (STRB_W > 1) ? $clog2(STRB_W) : 1;
  localparam int IDX_BITS  = $clog2(MEM_WORDS);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BEAT_BYTES = C_M_AXI_ADDR_WIDTH'(STRB_W);

  typedef enum logic {R_IDLE, R_BURST} rdState_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wrState_t;

  // FIXED bursts hold the address; INCR, WRAP and the reserved type all step
  // by one beat. WRAP/reserved are flagged as errors elsewhere.
  function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] nextAddr(
    input logic [C_M_AXI_ADDR_WIDTH-1:0] addr,
    input logic [1:0]                    burst
  );
    return (burst == 2'b00) ? addr : addr + BEAT_BYTES;
  endfunction

  logic [C_M_AXI_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  // read engine state
  rdState_t                       r_rdState, w_rdNext;
  logic [C_M_AXI_ADDR_WIDTH-1:0]  r_rdAddr;
  logic [7:0]                     r_rdLen, r_rdBeat;
  logic [1:0]                     r_rdBurst;
  logic                           r_rvalid, r_rlast;
  logic [1:0]                     r_rresp;
  logic [ID_WIDTH-1:0]            r_rid;
  logic [C_M_AXI_DATA_WIDTH-1:0]  r_rdata;

  // write engine state
  wrState_t                       r_wrState, w_wrNext;
  logic [C_M_AXI_ADDR_WIDTH-1:0]  r_wrAddr;
  logic [7:0]                     r_wrLen, r_wrBeat;
  logic [1:0]                     r_wrBurst;
  logic                           r_wrErr;
  logic [ID_WIDTH-1:0]            r_bid;

  logic w_arFire, w_rFire, w_awFire, w_wFire;
  logic w_unused;

  // Beat size is always the full bus width, so the size fields carry no information.
  assign w_unused = ^{s_axi_arsize, s_axi_awsize};

  assign w_arFire = s_axi_arvalid && s_axi_arready;
  assign w_rFire  = r_rvalid && s_axi_rready;
  assign w_awFire = s_axi_awvalid && s_axi_awready;
  assign w_wFire  = s_axi_wvalid && s_axi_wready;

  assign s_axi_rvalid = r_rvalid;
  assign s_axi_rdata  = r_rdata;
  assign s_axi_rresp  = r_rresp;
  assign s_axi_rlast  = r_rlast;
  assign s_axi_rid    = r_rid;
  assign s_axi_bresp  = r_wrErr ? 2'b10 : 2'b00;
  assign s_axi_bid    = r_bid;

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_rdState <= R_IDLE;
    else     r_rdState <= w_rdNext;
  end

  // Read FSM next state: accept AR only when idle, return after the rlast handshake.
  always_comb begin
    w_rdNext      = r_rdState;
    s_axi_arready = 1'b0;
    case (r_rdState)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) w_rdNext = R_BURST;
      end
      R_BURST: begin
        if (w_rFire && r_rlast) w_rdNext = R_IDLE;
      end
      default: w_rdNext = R_IDLE;
    endcase
  end

  // Read datapath: fetch first beat on the AR handshake, then prefetch the next
  // beat on each R handshake so data streams at one beat per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= 2'b00;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rdAddr  <= '0;
      r_rdLen   <= '0;
      r_rdBeat  <= '0;
      r_rdBurst <= 2'b00;
    end else if (w_arFire) begin
      r_rdata   <= r_mem[s_axi_araddr[BYTE_BITS +: IDX_BITS]];
      r_rdAddr  <= nextAddr(s_axi_araddr, s_axi_arburst);
      r_rdLen   <= s_axi_arlen;
      r_rdBurst <= s_axi_arburst;
      r_rid     <= s_axi_arid;
      r_rresp   <= s_axi_arburst[1] ? 2'b10 : 2'b00;
      r_rvalid  <= 1'b1;
      r_rlast   <= (s_axi_arlen == 8'd0);
      r_rdBeat  <= 8'd0;
    end else if (w_rFire) begin
      if (r_rlast) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end else begin
        r_rdata  <= r_mem[r_rdAddr[BYTE_BITS +: IDX_BITS]];
        r_rdAddr <= nextAddr(r_rdAddr, r_rdBurst);
        r_rdBeat <= r_rdBeat + 8'd1;
        r_rlast  <= ((r_rdBeat + 8'd1) == r_rdLen);
      end
    end
  end

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_wrState <= W_IDLE;
    else     r_wrState <= w_wrNext;
  end

  // Write FSM next state: the burst ends on the beat count, not on wlast.
  always_comb begin
    w_wrNext      = r_wrState;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (r_wrState)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) w_wrNext = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && (r_wrBeat == r_wrLen)) w_wrNext = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_wrNext = W_IDLE;
      end
      default: w_wrNext = W_IDLE;
    endcase
  end

  // Write bookkeeping: capture the burst, step the address, and latch any
  // error (bad burst type or wlast not coinciding with the final beat).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrAddr  <= '0;
      r_wrLen   <= '0;
      r_wrBeat  <= '0;
      r_wrBurst <= 2'b00;
      r_wrErr   <= 1'b0;
      r_bid     <= '0;
    end else if (w_awFire) begin
      r_wrAddr  <= s_axi_awaddr;
      r_wrLen   <= s_axi_awlen;
      r_wrBurst <= s_axi_awburst;
      r_bid     <= s_axi_awid;
      r_wrErr   <= s_axi_awburst[1];
      r_wrBeat  <= 8'd0;
    end else if (w_wFire) begin
      r_wrAddr <= nextAddr(r_wrAddr, r_wrBurst);
      r_wrBeat <= r_wrBeat + 8'd1;
      if (s_axi_wlast != (r_wrBeat == r_wrLen)) r_wrErr <= 1'b1;
    end
  end

  // RAM byte writes; no reset so contents survive rst. Reads elsewhere see
  // the pre-write value in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && w_wFire) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) r_mem[r_wrAddr[BYTE_BITS +: IDX_BITS]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

endmodule
